// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states, AXI constants and a constant clog2 helper for the I-cache.
package icache_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS_AR = 3'd2;
  localparam logic [2:0] S_MISS_R  = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ARCACHE    = 4'b0010;
  localparam logic [2:0] AXI_ARPROT     = 3'b100;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/icache_refill.sv
// icache_refill: issues the AR burst for a line and assembles R beats into a line buffer with a sticky error.
module icache_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 512,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_en,
  input  logic                  r_en,
  input  logic [ADDR_W-1:0]     line_addr,
  output logic [3:0]            axi_arid,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arlock,
  output logic [3:0]            axi_arcache,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  input  logic [AXI_DATA_W-1:0] axi_rdata,
  input  logic                  axi_rlast,
  output logic                  axi_rready,
  output logic                  done,
  output logic                  err,
  output logic [LINE_W-1:0]     line_buf
);
  localparam int BEATS = LINE_W / AXI_DATA_W;
  localparam int CNT_W = BEATS > 1 ? clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  logic [CNT_W-1:0] cnt;
  logic beat, fin;
  assign axi_arid    = 4'(AXI_ID);
  assign axi_araddr  = line_addr;
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = 3'(clog2(AXI_DATA_W / 8));
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = AXI_ARCACHE;
  assign axi_arprot  = AXI_ARPROT;
  assign axi_arvalid = ar_en;
  // rready drops in the result cycle so no beat of a following burst is swallowed
  assign axi_rready  = r_en && !done;
  assign beat = axi_rvalid && axi_rready;
  assign fin  = cnt == LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      line_buf <= '0;
    end else begin
      done <= beat && fin;
      if (ar_en && axi_arready) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (beat) begin
        cnt <= fin ? '0 : cnt + 1'b1;
        err <= err | (axi_rresp != AXI_RESP_OKAY) | (axi_rlast != fin);
        line_buf[int'(cnt)*AXI_DATA_W +: AXI_DATA_W] <= axi_rdata;
      end
    end
  end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache returning one full line per fetch, refilled over AXI4.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 512,
  parameter int AXI_DATA_W = 64,
  parameter int NUM_LINES  = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     req_pc,
  input  logic                  req_rd,
  output logic                  req_accept,
  output logic                  req_valid,
  output logic [LINE_W-1:0]     req_data,
  output logic                  req_err,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [3:0]            axi_arid,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arlock,
  output logic [3:0]            axi_arcache,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [3:0]            axi_rid,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  input  logic [AXI_DATA_W-1:0] axi_rdata,
  input  logic                  axi_rlast,
  output logic                  axi_rready
);
  localparam int OFF_W = clog2(LINE_W / 8);
  localparam int IDX_W = clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  logic [2:0]           st;
  logic [ADDR_W-1:0]    pc_q;
  logic                 flush_pend, flush_any;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag_q;
  logic                 hit, fill_done, fill_err;
  logic [LINE_W-1:0]    line_buf;
  logic                 unused_ok;
  assign idx       = pc_q[OFF_W +: IDX_W];
  assign tag_q     = pc_q[ADDR_W-1 -: TAG_W];
  assign hit       = valid[idx] && tag_arr[idx] == tag_q;
  assign flush_any = flush_pend || flush_req;
  assign unused_ok = ^{axi_rid, pc_q[OFF_W-1:0]};
  assign req_accept = rst && st == S_IDLE && !flush_req;
  assign req_valid  = (st == S_LOOKUP && hit) || (st == S_MISS_R && fill_done);
  assign req_err    = st == S_MISS_R && fill_done && fill_err;
  assign req_data   = st == S_LOOKUP ? data_arr[idx] : line_buf;
  assign flush_done = st == S_FLUSH;
  icache_refill #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .AXI_DATA_W(AXI_DATA_W), .AXI_ID(AXI_ID)
  ) u_refill (
    .clk(clk), .rst(rst),
    .ar_en(st == S_MISS_AR), .r_en(st == S_MISS_R),
    .line_addr({pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .done(fill_done), .err(fill_err), .line_buf(line_buf)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_IDLE;
      pc_q       <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
    end else begin
      flush_pend <= st == S_FLUSH ? 1'b0 : flush_pend | (flush_req && st != S_IDLE);
      case (st)
        S_IDLE: begin
          if (flush_req) st <= S_FLUSH;
          else if (req_rd) begin
            pc_q <= req_pc;
            st   <= S_LOOKUP;
          end
        end
        S_LOOKUP:  st <= hit ? (flush_any ? S_FLUSH : S_IDLE) : S_MISS_AR;
        S_MISS_AR: st <= axi_arready ? S_MISS_R : S_MISS_AR;
        S_MISS_R: begin
          if (fill_done) begin
            st <= flush_any ? S_FLUSH : S_IDLE;
            if (!fill_err) valid[idx] <= 1'b1;
          end
        end
        S_FLUSH: begin
          valid <= '0;
          st    <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
  // tag/data storage needs no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (st == S_MISS_R && fill_done && !fill_err) begin
      tag_arr[idx]  <= tag_q;
      data_arr[idx] <= line_buf;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scenarios for icache_dm with an inline AXI slave and hand-computed expectations.
module tb_icache_dm;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [31:0]  req_pc = '0;
  logic         req_rd = 0, req_accept, req_valid, req_err, flush_req = 0, flush_done;
  logic [511:0] req_data;
  logic [3:0]   axi_arid, axi_arcache, axi_rid = '0;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize, axi_arprot;
  logic [1:0]   axi_arburst, axi_rresp = '0;
  logic         axi_arlock, axi_arvalid, axi_arready = 0, axi_rvalid = 0, axi_rlast = 0, axi_rready;
  logic [63:0]  axi_rdata = '0;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  icache_dm dut (
    .clk(clk), .rst(rst), .req_pc(req_pc), .req_rd(req_rd), .req_accept(req_accept),
    .req_valid(req_valid), .req_data(req_data), .req_err(req_err),
    .flush_req(flush_req), .flush_done(flush_done),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready)
  );

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic fetch(input logic [31:0] pc);
    int n = 0;
    while (!req_accept && n < 50) begin @(negedge clk); n++; end
    if (!req_accept) begin errors++; $display("FAIL fetch_accept pc=%h never accepted", pc); end
    req_pc = pc; req_rd = 1;
    @(negedge clk);
    req_rd = 0;
  endtask

  task automatic serve(input int ar_delay, input int err_beat, input int flush_beat, input logic [63:0] base,
                       output logic [31:0] addr, output logic [7:0] len, output logic [2:0] size,
                       output logic [1:0] burst, output bit stable, output bit rv,
                       output logic [511:0] data, output logic err);
    int n = 0;
    stable = 1;
    while (!axi_arvalid && n < 20) begin @(negedge clk); n++; end
    if (!axi_arvalid) begin errors++; $display("FAIL arvalid_timeout got=0 want=1"); end
    addr = axi_araddr; len = axi_arlen; size = axi_arsize; burst = axi_arburst;
    repeat (ar_delay) begin
      @(negedge clk);
      if (!axi_arvalid || axi_araddr !== addr) stable = 0;
    end
    axi_arready = 1;
    @(negedge clk);
    axi_arready = 0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!axi_rready && n < 20) begin @(negedge clk); n++; end
      if (!axi_rready) begin errors++; $display("FAIL rready_timeout beat=%0d", k); end
      axi_rvalid = 1; axi_rdata = base + 64'(k);
      axi_rresp = k == err_beat ? 2'b10 : 2'b00;
      axi_rlast = k == 7; flush_req = k == flush_beat;
      @(negedge clk);
    end
    axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0; flush_req = 0;
    n = 0;
    while (!req_valid && n < 20) begin @(negedge clk); n++; end
    rv = req_valid; data = req_data; err = req_err;
  endtask

  logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
  bit st_ok, rv; logic [511:0] d; logic e;

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (req_accept !== 0) begin errors++; $display("FAIL reset_accept got=%b want=0", req_accept); end
    checks++; if ({req_valid, req_err, flush_done, axi_arvalid, axi_rready} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=00000", {req_valid, req_err, flush_done, axi_arvalid, axi_rready}); end
    checks++; if (req_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", req_data); end
    rst = 1;
    @(negedge clk);
    checks++; if (req_accept !== 1) begin errors++; $display("FAIL idle_accept got=%b want=1", req_accept); end
  endtask

  task automatic test_cold_miss;
    fetch(32'h1040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL cold_lookup_valid got=%b want=0", req_valid); end
    @(negedge clk);
    checks++; if ({axi_arvalid, axi_arid, axi_arlock, axi_arcache, axi_arprot} !== {1'b1, 4'h0, 1'b0, 4'b0010, 3'b100}) begin errors++; $display("FAIL cold_ar_attr got=%b%h%b%h%h want=1002 4", axi_arvalid, axi_arid, axi_arlock, axi_arcache, axi_arprot); end
    serve(0, -1, -1, 64'h1, a, l, s, b, st_ok, rv, d, e);
    checks++; if (a !== 32'h1040) begin errors++; $display("FAIL cold_araddr got=%h want=00001040", a); end
    checks++; if ({l, s, b} !== {8'd7, 3'd3, 2'd1}) begin errors++; $display("FAIL cold_len_size_burst got=%0d/%0d/%0d want=7/3/1", l, s, b); end
    checks++; if (rv !== 1 || e !== 0) begin errors++; $display("FAIL cold_valid_err got=%b/%b want=1/0", rv, e); end
    checks++; if (d[63:0] !== 64'h1 || d[511:448] !== 64'h8) begin errors++; $display("FAIL cold_edges got=%h/%h want=1/8", d[63:0], d[511:448]); end
    checks++; if (d !== mk_line(64'h1)) begin errors++; $display("FAIL cold_line got=%h want=%h", d, mk_line(64'h1)); end
    @(negedge clk);
  endtask

  task automatic test_hit;
    fetch(32'h1078);
    checks++; if (req_valid !== 1 || req_err !== 0) begin errors++; $display("FAIL hit_valid got=%b/%b want=1/0", req_valid, req_err); end
    checks++; if (req_data !== mk_line(64'h1)) begin errors++; $display("FAIL hit_data got=%h want=%h", req_data, mk_line(64'h1)); end
    checks++; if (axi_arvalid !== 0) begin errors++; $display("FAIL hit_arvalid got=%b want=0", axi_arvalid); end
    @(negedge clk);
    checks++; if (req_valid !== 0 || req_accept !== 1 || axi_arvalid !== 0) begin errors++; $display("FAIL hit_after got=%b%b%b want=010", req_valid, req_accept, axi_arvalid); end
  endtask

  task automatic test_back_to_back;
    int t0;
    fetch(32'h1040);
    t0 = cyc;
    checks++; if (req_valid !== 1) begin errors++; $display("FAIL b2b_first got=%b want=1", req_valid); end
    fetch(32'h1058);
    checks++; if (req_valid !== 1 || cyc - t0 !== 2) begin errors++; $display("FAIL b2b_second valid=%b gap=%0d want=1/2", req_valid, cyc - t0); end
    @(negedge clk);
  endtask

  task automatic test_conflict;
    fetch(32'h2040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL conflict_miss got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h100, a, l, s, b, st_ok, rv, d, e);
    checks++; if (a !== 32'h2040 || d !== mk_line(64'h100) || rv !== 1) begin errors++; $display("FAIL conflict_fill addr=%h rv=%b want=00002040/1", a, rv); end
    @(negedge clk);
    fetch(32'h1040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL conflict_evict got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h1, a, l, s, b, st_ok, rv, d, e);
    checks++; if (d !== mk_line(64'h1) || e !== 0) begin errors++; $display("FAIL conflict_refill err=%b want=0", e); end
    @(negedge clk);
  endtask

  task automatic test_stall_err;
    fetch(32'h3080);
    serve(5, 3, -1, 64'h200, a, l, s, b, st_ok, rv, d, e);
    checks++; if (st_ok !== 1 || a !== 32'h3080) begin errors++; $display("FAIL stall_stable got=%b addr=%h want=1/00003080", st_ok, a); end
    checks++; if (rv !== 1 || e !== 1) begin errors++; $display("FAIL err_report got=%b/%b want=1/1", rv, e); end
    @(negedge clk);
    fetch(32'h3080);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL err_not_installed got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h300, a, l, s, b, st_ok, rv, d, e);
    checks++; if (e !== 0 || d !== mk_line(64'h300)) begin errors++; $display("FAIL err_recover err=%b want=0", e); end
    @(negedge clk);
    fetch(32'h30a0);
    checks++; if (req_valid !== 1 || req_data !== mk_line(64'h300)) begin errors++; $display("FAIL err_rehit got=%b want=1", req_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    fetch(32'h1040);
    checks++; if (req_valid !== 1) begin errors++; $display("FAIL pre_reset_hit got=%b want=1", req_valid); end
    @(negedge clk);
    fetch(32'h5000);
    @(negedge clk);
    axi_arready = 1;
    @(negedge clk);
    axi_arready = 0;
    for (int k = 0; k < 3; k++) begin
      axi_rvalid = 1; axi_rdata = 64'h900 + 64'(k);
      @(negedge clk);
    end
    rst = 0;
    #1;
    checks++; if ({req_accept, req_valid, req_err, flush_done, axi_arvalid, axi_rready} !== 6'b0) begin errors++; $display("FAIL midrst_ctrl got=%b want=000000", {req_accept, req_valid, req_err, flush_done, axi_arvalid, axi_rready}); end
    checks++; if (req_data !== '0) begin errors++; $display("FAIL midrst_data got=%h want=0", req_data); end
    @(negedge clk);
    axi_rvalid = 0; rst = 1;
    @(negedge clk);
    fetch(32'h1040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL post_reset_miss got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h400, a, l, s, b, st_ok, rv, d, e);
    checks++; if (rv !== 1 || d !== mk_line(64'h400)) begin errors++; $display("FAIL post_reset_fill got=%b want=1", rv); end
    @(negedge clk);
  endtask

  task automatic test_flush_miss_r;
    fetch(32'h6040);
    serve(0, -1, 2, 64'h500, a, l, s, b, st_ok, rv, d, e);
    checks++; if (rv !== 1 || flush_done !== 0 || d !== mk_line(64'h500)) begin errors++; $display("FAIL flush_fill rv=%b fd=%b want=1/0", rv, flush_done); end
    @(negedge clk);
    checks++; if (flush_done !== 1) begin errors++; $display("FAIL flush_done got=%b want=1", flush_done); end
    @(negedge clk);
    checks++; if (flush_done !== 0 || req_accept !== 1) begin errors++; $display("FAIL flush_once got=%b/%b want=0/1", flush_done, req_accept); end
    fetch(32'h6040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL flush_miss got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h600, a, l, s, b, st_ok, rv, d, e);
    @(negedge clk);
  endtask

  task automatic test_flush_idle;
    flush_req = 1; req_rd = 1; req_pc = 32'h6040;
    #1;
    checks++; if (req_accept !== 0) begin errors++; $display("FAIL flush_prio_accept got=%b want=0", req_accept); end
    @(negedge clk);
    flush_req = 0; req_rd = 0;
    checks++; if (flush_done !== 1 || req_valid !== 0) begin errors++; $display("FAIL flush_prio_done got=%b/%b want=1/0", flush_done, req_valid); end
    @(negedge clk);
    fetch(32'h6040);
    checks++; if (req_valid !== 0) begin errors++; $display("FAIL flush_idle_miss got=%b want=0", req_valid); end
    serve(0, -1, -1, 64'h700, a, l, s, b, st_ok, rv, d, e);
    checks++; if (rv !== 1 || d !== mk_line(64'h700)) begin errors++; $display("FAIL flush_idle_fill got=%b want=1", rv); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_stall_err();
    test_reset_mid();
    test_flush_miss_r();
    test_flush_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
